// File: rtl/mbscore_lsu_if.sv
// Bundle of the execute-side, data-memory, writeback and exception signals of the LSU.
// The LSU uses the slave modport; its environment (pipeline + memory) uses master.
interface mbscore_lsu_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      ex_valid;
  logic                      ex_ready;
  logic [3:0]                ex_op;
  logic [DATA_WIDTH-1:0]     ex_addr;
  logic [DATA_WIDTH-1:0]     ex_wdata;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;

  logic                      dmem_req;
  logic                      dmem_we;
  logic [DATA_WIDTH-1:0]     dmem_addr;
  logic [3:0]                dmem_be;
  logic [DATA_WIDTH-1:0]     dmem_wdata;
  logic                      dmem_gnt;
  logic                      dmem_rvalid;
  logic [DATA_WIDTH-1:0]     dmem_rdata;

  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;

  logic                      exc_valid;
  logic [1:0]                exc_cause;
  logic [DATA_WIDTH-1:0]     exc_addr;

  modport slave (
    input  ex_valid, ex_op, ex_addr, ex_wdata, ex_rd,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output ex_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_valid, wb_rd, wb_data,
    output exc_valid, exc_cause, exc_addr
  );

  modport master (
    output ex_valid, ex_op, ex_addr, ex_wdata, ex_rd,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  ex_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_valid, wb_rd, wb_data,
    input  exc_valid, exc_cause, exc_addr
  );
endinterface

// File: rtl/mbscore_lsu.sv
// Single-outstanding load/store unit: byte/half/word accesses over a req/gnt/rvalid
// data-memory port, with alignment checking and sign/zero-extended load writeback.
module mbscore_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic          clk,
  input logic          rst_n,
  mbscore_lsu_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    EXC
  } state_t;

  state_t state, state_next;

  logic                      accept;
  logic [1:0]                ex_size;
  logic                      ex_store;
  logic [1:0]                fault_cause;
  logic                      fault;
  logic [3:0]                st_be;
  logic [DATA_WIDTH-1:0]     st_wdata;

  logic [3:0]                op_q;
  logic [1:0]                addr_lo_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     dmem_addr_q;
  logic [3:0]                dmem_be_q;
  logic [DATA_WIDTH-1:0]     dmem_wdata_q;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;
  logic [1:0]                exc_cause_q;
  logic [DATA_WIDTH-1:0]     exc_addr_q;

  logic [DATA_WIDTH-1:0]     rdata_shifted;
  logic [15:0]               rdata_half;
  logic [DATA_WIDTH-1:0]     load_ext;

  assign accept   = bus.ex_valid && (state == IDLE);
  assign ex_size  = bus.ex_op[1:0];
  assign ex_store = bus.ex_op[3];

  // Fault decode on the incoming op; cause 00 means the access is legal.
  always_comb begin
    fault_cause = 2'b00;
    case (ex_size)
      2'b11: fault_cause = 2'b11;
      2'b10: if (bus.ex_addr[1:0] != 2'b00) fault_cause = ex_store ? 2'b10 : 2'b01;
      2'b01: if (bus.ex_addr[0])            fault_cause = ex_store ? 2'b10 : 2'b01;
      default: fault_cause = 2'b00;
    endcase
  end

  assign fault = (fault_cause != 2'b00);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = bus.ex_wdata;
    case (ex_size)
      2'b00: begin
        st_be    = 4'b0001 << bus.ex_addr[1:0];
        st_wdata = {4{bus.ex_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = bus.ex_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{bus.ex_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = bus.ex_wdata;
      end
    endcase
  end

  // Lane selection and extension of returning read data, driven by the latched op.
  always_comb begin
    rdata_shifted = bus.dmem_rdata >> {addr_lo_q, 3'b000};
    rdata_half    = addr_lo_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    load_ext      = bus.dmem_rdata;
    case (op_q[1:0])
      2'b00: load_ext = op_q[2] ? {24'b0, rdata_shifted[7:0]}
                                : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01: load_ext = op_q[2] ? {16'b0, rdata_half}
                                : {{16{rdata_half[15]}}, rdata_half};
      default: load_ext = bus.dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.ex_ready  = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.wb_valid  = 1'b0;
    bus.exc_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.ex_ready = 1'b1;
        if (bus.ex_valid) state_next = fault ? EXC : REQ;
      end
      REQ: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = op_q[3];
        if (bus.dmem_gnt) state_next = op_q[3] ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus.dmem_rvalid) state_next = RESP;
      end
      RESP: begin
        bus.wb_valid = 1'b1;
        state_next   = IDLE;
      end
      EXC: begin
        bus.exc_valid = 1'b1;
        state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory-side fields only change on a legal accept, so they stay stable until gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= '0;
      addr_lo_q    <= '0;
      rd_q         <= '0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      exc_cause_q  <= '0;
      exc_addr_q   <= '0;
    end else begin
      if (accept) begin
        op_q      <= bus.ex_op;
        addr_lo_q <= bus.ex_addr[1:0];
        rd_q      <= bus.ex_rd;
        if (fault) begin
          exc_cause_q <= fault_cause;
          exc_addr_q  <= bus.ex_addr;
        end else begin
          dmem_addr_q  <= {bus.ex_addr[DATA_WIDTH-1:2], 2'b00};
          dmem_be_q    <= st_be;
          dmem_wdata_q <= st_wdata;
        end
      end
      if ((state == WAIT) && bus.dmem_rvalid) begin
        wb_data_q <= load_ext;
        wb_rd_q   <= rd_q;
      end
    end
  end

  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_be    = dmem_be_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.exc_cause  = exc_cause_q;
  assign bus.exc_addr   = exc_addr_q;

endmodule

// File: tb/tb_mbscore_lsu.sv
// Scoreboard bench for mbscore_lsu: expected memory requests, writebacks and exceptions
// are queued when an op is driven and popped when the LSU produces them.
module tb_mbscore_lsu;

  logic clk;
  logic rst_n;

  mbscore_lsu_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  mbscore_lsu #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct packed {
    logic [1:0]  cause;
    logic [31:0] addr;
  } exc_exp_t;

  req_exp_t req_q[$];
  wb_exp_t  wb_q[$];
  exc_exp_t exc_q[$];

  int n_compared;
  int n_mismatched;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BAD = 4'b0011;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Monitor on the falling edge: checks every output event against the scoreboard.
  always @(negedge clk) begin
    req_exp_t r;
    wb_exp_t  w;
    exc_exp_t x;
    if (rst_n) begin
      if (bus.dmem_req) begin
        if (req_q.size() == 0) begin
          checkOutput("req_unexpected", 32'd1, 32'd0);
        end else begin
          r = req_q[0];
          checkOutput("req_we",    {31'b0, bus.dmem_we}, {31'b0, r.we});
          checkOutput("req_addr",  bus.dmem_addr, r.addr);
          checkOutput("req_be",    {28'b0, bus.dmem_be}, {28'b0, r.be});
          checkOutput("req_wdata", bus.dmem_wdata, r.wdata);
          if (bus.dmem_gnt) void'(req_q.pop_front());
        end
      end
      if (bus.wb_valid) begin
        if (wb_q.size() == 0) begin
          checkOutput("wb_unexpected", 32'd1, 32'd0);
        end else begin
          w = wb_q.pop_front();
          checkOutput("wb_rd",   {27'b0, bus.wb_rd}, {27'b0, w.rd});
          checkOutput("wb_data", bus.wb_data, w.data);
        end
      end
      if (bus.exc_valid) begin
        if (exc_q.size() == 0) begin
          checkOutput("exc_unexpected", 32'd1, 32'd0);
        end else begin
          x = exc_q.pop_front();
          checkOutput("exc_cause", {30'b0, bus.exc_cause}, {30'b0, x.cause});
          checkOutput("exc_addr",  bus.exc_addr, x.addr);
        end
      end
    end
  end

  task automatic waitReady();
    int n;
    n = 0;
    while (!bus.ex_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.ex_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  // Drives one op, plays the memory with the given gnt delay and read data, and
  // queues what the LSU should produce according to the reference model below.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input int gnt_delay, input logic [31:0] rdata);
    logic [1:0]  sz;
    logic        st;
    logic        uns;
    logic [1:0]  cause;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld;
    sz  = op[1:0];
    st  = op[3];
    uns = op[2];
    if (sz == 2'b11) cause = 2'b11;
    else if ((sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)) cause = st ? 2'b10 : 2'b01;
    else cause = 2'b00;

    case (addr[1:0])
      2'b00: b = rdata[7:0];
      2'b01: b = rdata[15:8];
      2'b10: b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (sz)
      2'b00: begin
        be = 4'b0001 << addr[1:0];
        wd = {wdata[7:0], wdata[7:0], wdata[7:0], wdata[7:0]};
        ld = uns ? {24'b0, b} : {{24{b[7]}}, b};
      end
      2'b01: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {wdata[15:0], wdata[15:0]};
        ld = uns ? {16'b0, h} : {{16{h[15]}}, h};
      end
      default: begin
        be = 4'b1111;
        wd = wdata;
        ld = rdata;
      end
    endcase

    waitReady();
    if (cause != 2'b00) exc_q.push_back('{cause: cause, addr: addr});
    else begin
      req_q.push_back('{we: st, addr: {addr[31:2], 2'b00}, be: be, wdata: wd});
      if (!st) wb_q.push_back('{rd: rd, data: ld});
    end
    bus.ex_valid = 1'b1;
    bus.ex_op    = op;
    bus.ex_addr  = addr;
    bus.ex_wdata = wdata;
    bus.ex_rd    = rd;
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;

    if (cause != 2'b00) begin
      checkOutput("exc_latency", {31'b0, bus.exc_valid}, 32'd1);
      @(posedge clk); #1;
      checkOutput("exc_ready", {31'b0, bus.ex_ready}, 32'd1);
    end else begin
      checkOutput("req_latency", {31'b0, bus.dmem_req}, 32'd1);
      for (int i = 0; i < gnt_delay; i++) begin
        @(posedge clk); #1;
      end
      bus.dmem_gnt = 1'b1;
      @(posedge clk); #1;
      bus.dmem_gnt = 1'b0;
      if (st) begin
        checkOutput("st_ready", {31'b0, bus.ex_ready}, 32'd1);
      end else begin
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = rdata;
        @(posedge clk); #1;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'hA5A5_A5A5;
        checkOutput("ld_wb_latency", {31'b0, bus.wb_valid}, 32'd1);
        @(posedge clk); #1;
        checkOutput("ld_ready", {31'b0, bus.ex_ready}, 32'd1);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_compared      = 0;
    n_mismatched    = 0;
    rst_n           = 1'b0;
    bus.ex_valid    = 1'b0;
    bus.ex_op       = '0;
    bus.ex_addr     = '0;
    bus.ex_wdata    = '0;
    bus.ex_rd       = '0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'hA5A5_A5A5;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ex_ready",  {31'b0, bus.ex_ready}, 32'd1);
    checkOutput("rst_dmem_req",  {31'b0, bus.dmem_req}, 32'd0);
    checkOutput("rst_dmem_we",   {31'b0, bus.dmem_we}, 32'd0);
    checkOutput("rst_dmem_addr", bus.dmem_addr, 32'd0);
    checkOutput("rst_dmem_be",   {28'b0, bus.dmem_be}, 32'd0);
    checkOutput("rst_dmem_wd",   bus.dmem_wdata, 32'd0);
    checkOutput("rst_wb_valid",  {31'b0, bus.wb_valid}, 32'd0);
    checkOutput("rst_wb_data",   bus.wb_data, 32'd0);
    checkOutput("rst_exc_valid", {31'b0, bus.exc_valid}, 32'd0);
    checkOutput("rst_exc_addr",  bus.exc_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(OP_SW,  32'h0000_0100, 32'hDEAD_BEEF, 5'd0,  0, 32'h0);
    applyStimulus(OP_LB,  32'h0000_0203, 32'h0,         5'd3,  0, 32'h80FF_0000);
    applyStimulus(OP_LBU, 32'h0000_0203, 32'h0,         5'd4,  0, 32'h80FF_0000);
    applyStimulus(OP_SH,  32'h0000_0302, 32'h1234_ABCD, 5'd0,  3, 32'h0);
    applyStimulus(OP_LW,  32'h0000_0401, 32'h0,         5'd5,  0, 32'h0);
    applyStimulus(OP_SH,  32'h0000_0003, 32'h0,         5'd0,  0, 32'h0);
    applyStimulus(OP_BAD, 32'h0000_0010, 32'h0,         5'd6,  0, 32'h0);
    applyStimulus(OP_LH,  32'h0000_0002, 32'h0,         5'd7,  1, 32'h8001_7F00);
    applyStimulus(OP_LHU, 32'h0000_0002, 32'h0,         5'd8,  0, 32'h8001_7F00);
    applyStimulus(OP_LH,  32'h0000_0000, 32'h0,         5'd9,  0, 32'h1234_F00F);
    applyStimulus(OP_LW,  32'h0000_0404, 32'h0,         5'd10, 2, 32'hCAFE_F00D);
    applyStimulus(OP_SB,  32'h0000_0101, 32'h0000_005A, 5'd0,  0, 32'h0);
    applyStimulus(OP_LB,  32'h0000_0101, 32'h0,         5'd11, 0, 32'h0000_7F00);
    applyStimulus(OP_SW,  32'h0000_0402, 32'h1111_2222, 5'd0,  0, 32'h0);
    applyStimulus(OP_LH,  32'h0000_0105, 32'h0,         5'd12, 0, 32'h0);

    // Reset while a request is waiting for gnt: dmem_req must fall without a clock edge.
    waitReady();
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0500, be: 4'b1100, wdata: 32'h0});
    bus.ex_valid = 1'b1;
    bus.ex_op    = OP_LH;
    bus.ex_addr  = 32'h0000_0502;
    bus.ex_wdata = 32'h0;
    bus.ex_rd    = 5'd13;
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    checkOutput("rst_req_before", {31'b0, bus.dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_req_drop", {31'b0, bus.dmem_req}, 32'd0);
    checkOutput("rst_req_ready", {31'b0, bus.ex_ready}, 32'd1);
    req_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset while a load sits in WAIT: the stale response must not reach writeback.
    req_q.push_back('{we: 1'b0, addr: 32'h0000_0600, be: 4'b0011, wdata: 32'h0});
    bus.ex_valid = 1'b1;
    bus.ex_op    = OP_LH;
    bus.ex_addr  = 32'h0000_0600;
    bus.ex_rd    = 5'd14;
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
    bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_wait_ready", {31'b0, bus.ex_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h0000_8888;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stale_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
      @(posedge clk); #1;
    end
    checkOutput("stale_wb_data", bus.wb_data, 32'd0);

    applyStimulus(OP_LB, 32'h0000_0700, 32'h0, 5'd15, 0, 32'h0000_00FE);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("sb_req_empty", req_q.size(), 32'd0);
    checkOutput("sb_wb_empty",  wb_q.size(),  32'd0);
    checkOutput("sb_exc_empty", exc_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
